// File: rtl/codec_cfg_pkg.sv
// Shared types, WM8731 register map and word packing for the codec configuration sequencer.
package codec_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_PWR,
        ST_LOAD,
        ST_REQ,
        ST_WAIT_DONE,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } cfg_state_t;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h1A;

    localparam logic [6:0] R0_LLINE    = 7'h00;
    localparam logic [6:0] R1_RLINE    = 7'h01;
    localparam logic [6:0] R2_LHP      = 7'h02;
    localparam logic [6:0] R3_RHP      = 7'h03;
    localparam logic [6:0] R4_ANALOG   = 7'h04;
    localparam logic [6:0] R5_DIGITAL  = 7'h05;
    localparam logic [6:0] R6_POWER    = 7'h06;
    localparam logic [6:0] R7_FORMAT   = 7'h07;
    localparam logic [6:0] R8_SAMPLING = 7'h08;
    localparam logic [6:0] R9_ACTIVE   = 7'h09;
    localparam logic [6:0] R15_RESET   = 7'h0F;

    // WM8731 control word: 7-bit register address followed by 9-bit data.
    function automatic logic [15:0] codec_word(input logic [6:0] addr, input logic [8:0] data);
        return {addr, data};
    endfunction

endpackage

// File: rtl/codec_cfg_rom.sv
// Fixed WM8731 bring-up table, indexed by entry number.
module codec_cfg_rom
    import codec_cfg_pkg::*;
(
    input  logic [3:0]  idx,
    output logic [15:0] word
);

    always_comb begin
        word = '0;
        case (idx)
            4'd0:    word = codec_word(R15_RESET,   9'h000);
            4'd1:    word = codec_word(R0_LLINE,    9'h017);
            4'd2:    word = codec_word(R1_RLINE,    9'h017);
            4'd3:    word = codec_word(R2_LHP,      9'h079);
            4'd4:    word = codec_word(R3_RHP,      9'h079);
            4'd5:    word = codec_word(R4_ANALOG,   9'h012);
            4'd6:    word = codec_word(R5_DIGITAL,  9'h000);
            4'd7:    word = codec_word(R6_POWER,    9'h000);
            4'd8:    word = codec_word(R7_FORMAT,   9'h002);
            4'd9:    word = codec_word(R8_SAMPLING, 9'h000);
            4'd10:   word = codec_word(R9_ACTIVE,   9'h001);
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/codec_cfg_seq.sv
// Walks the codec register table, issuing one I2C write per entry with NACK retry and inter-write gap.
module codec_cfg_seq
    import codec_cfg_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR       = DEV_ADDR_DEFAULT,
    parameter int unsigned N_REGS         = 11,
    parameter logic [23:0] STARTUP_CYCLES = 24'd1_000_000,
    parameter logic [15:0] GAP_CYCLES     = 16'd5000,
    parameter int unsigned MAX_RETRY      = 3,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        i2c_req,
    input  logic        i2c_ack,
    output logic [6:0]  i2c_dev,
    output logic [15:0] i2c_word,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    output logic        busy,
    output logic        cfg_done,
    output logic        cfg_error,
    output logic [3:0]  cur_idx
);

    localparam int unsigned RW          = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
    localparam logic [3:0]  LAST_IDX    = 4'(N_REGS - 1);
    localparam logic [23:0] PWR_LAST    = STARTUP_CYCLES - 24'd1;
    localparam logic [15:0] GAP_LAST    = GAP_CYCLES - 16'd1;
    localparam cfg_state_t  RESET_STATE = AUTO_START ? ST_WAIT_PWR : ST_IDLE;

    cfg_state_t    state;
    logic [23:0]   pwr_cnt;
    logic [15:0]   gap_cnt;
    logic [RW-1:0] retry;
    logic [3:0]    idx;
    logic [15:0]   rom_word;

    codec_cfg_rom u_rom (
        .idx  (idx),
        .word (rom_word)
    );

    assign i2c_dev = DEV_ADDR;
    assign cur_idx = idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RESET_STATE;
            pwr_cnt   <= '0;
            gap_cnt   <= '0;
            retry     <= '0;
            idx       <= '0;
            i2c_req   <= 1'b0;
            i2c_word  <= '0;
            busy      <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state     <= ST_LOAD;
                        idx       <= '0;
                        retry     <= '0;
                        busy      <= 1'b1;
                        cfg_done  <= 1'b0;
                        cfg_error <= 1'b0;
                    end
                end
                ST_WAIT_PWR: begin
                    busy <= 1'b1;
                    if (start || STARTUP_CYCLES == '0 || pwr_cnt == PWR_LAST) begin
                        state     <= ST_LOAD;
                        pwr_cnt   <= '0;
                        idx       <= '0;
                        retry     <= '0;
                        cfg_done  <= 1'b0;
                        cfg_error <= 1'b0;
                    end else begin
                        pwr_cnt <= pwr_cnt + 24'd1;
                    end
                end
                ST_LOAD: begin
                    i2c_word <= rom_word;
                    i2c_req  <= 1'b1;
                    state    <= ST_REQ;
                end
                ST_REQ: begin
                    if (i2c_ack) begin
                        i2c_req <= 1'b0;
                        state   <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (i2c_done) begin
                        if (!i2c_nack) begin
                            if (idx == LAST_IDX) begin
                                state    <= ST_DONE;
                                busy     <= 1'b0;
                                cfg_done <= 1'b1;
                            end else begin
                                idx     <= idx + 4'd1;
                                retry   <= '0;
                                gap_cnt <= '0;
                                state   <= ST_GAP;
                            end
                        end else if (retry < RETRY_LIM) begin
                            // retry keeps idx, so the next LOAD re-reads the same word
                            retry   <= retry + RW'(1);
                            gap_cnt <= '0;
                            state   <= ST_GAP;
                        end else begin
                            state     <= ST_ERROR;
                            busy      <= 1'b0;
                            cfg_error <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (GAP_CYCLES == '0 || gap_cnt == GAP_LAST) begin
                        state <= ST_LOAD;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    i2c_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_codec_cfg_seq.sv
// Scoreboard bench: expected writes come from a table-level pass model, an I2C slave model answers requests.
module tb_codec_cfg_seq;

    localparam int STARTUP = 8;
    localparam int GAP     = 4;
    localparam int MAXR    = 3;
    localparam int NREG    = 11;

    typedef struct {
        int          idx;
        logic [15:0] word;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        start, i2c_req, i2c_ack, i2c_done, i2c_nack, busy, cfg_done, cfg_error;
    logic [6:0]  i2c_dev;
    logic [15:0] i2c_word;
    logic [3:0]  cur_idx;

    logic        start1, req1, ack1, done1, nack1, busy1, cfg_done1, cfg_error1;
    logic [6:0]  dev1;
    logic [15:0] word1;
    logic [3:0]  idx1;
    assign nack1 = 1'b0;

    codec_cfg_seq #(
        .DEV_ADDR(7'h1A), .N_REGS(NREG), .STARTUP_CYCLES(24'd8), .GAP_CYCLES(16'd4),
        .MAX_RETRY(MAXR), .AUTO_START(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .i2c_req(i2c_req), .i2c_ack(i2c_ack),
        .i2c_dev(i2c_dev), .i2c_word(i2c_word), .i2c_done(i2c_done), .i2c_nack(i2c_nack),
        .busy(busy), .cfg_done(cfg_done), .cfg_error(cfg_error), .cur_idx(cur_idx)
    );

    codec_cfg_seq #(
        .DEV_ADDR(7'h1A), .N_REGS(NREG), .STARTUP_CYCLES(24'd8), .GAP_CYCLES(16'd4),
        .MAX_RETRY(MAXR), .AUTO_START(1'b0)
    ) dut_manual (
        .clk(clk), .reset_n(reset_n), .start(start1), .i2c_req(req1), .i2c_ack(ack1),
        .i2c_dev(dev1), .i2c_word(word1), .i2c_done(done1), .i2c_nack(nack1),
        .busy(busy1), .cfg_done(cfg_done1), .cfg_error(cfg_error1), .cur_idx(idx1)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];
    exp_t sb_e;

    int unsigned tbl_addr[NREG] = '{15, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    int unsigned tbl_data[NREG] = '{'h000, 'h017, 'h017, 'h079, 'h079, 'h012, 'h000, 'h000, 'h002, 'h000, 'h001};

    int nack_idx = -1, nack_times = 0;
    int att[16];
    bit fixed_dly = 1'b1, spurious = 1'b0;
    bit s_active = 1'b0;
    int s_cnt, s_idx, ack_dly, done_dly, exp_hi;
    logic req_prev;
    int hi_cnt = 0, low_cnt = 1000, n_req = 0;

    bit   s1_act = 1'b0, started1 = 1'b0;
    logic prev1;
    int   s1_cnt, n_req1 = 0;

    int lat, nr, cyc;
    bit exp_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Expected request stream for one pass: each entry is repeated once per NACK until the retry budget runs out.
    function automatic bit model_pass(input int nidx, input int ntimes, input int limit);
        for (int i = 0; i < NREG; i++) begin
            if (i >= limit) return 1'b0;
            for (int a = 0; a <= MAXR; a++) begin
                exp_t e;
                e.idx  = i;
                e.word = 16'(tbl_addr[i] * 512 + tbl_data[i]);
                sb_q.push_back(e);
                if (!(i == nidx && a < ntimes)) break;
                if (a == MAXR) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Monitor then slave, in one process so the observation order within a cycle is fixed.
    always @(negedge clk) begin
        if (!reset_n) begin
            req_prev = 1'b0; s_active = 1'b0; hi_cnt = 0; low_cnt = 1000;
            i2c_ack = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0;
        end else begin
            if (i2c_req && !req_prev) begin
                n_req++;
                if (sb_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_req: actual idx %0d word %h required no request", cur_idx, i2c_word);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("req_word", i2c_word, sb_e.word);
                    check("req_idx", cur_idx, sb_e.idx);
                end
                check("req_spacing", low_cnt >= GAP, 1);
                check("req_dev", i2c_dev, 7'h1A);
                hi_cnt = 0;
            end
            if (!i2c_req && req_prev) begin
                check("req_width", hi_cnt, exp_hi);
                low_cnt = 0;
            end
            if (i2c_req) hi_cnt++; else low_cnt++;
            req_prev = i2c_req;

            i2c_ack = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0;
            if (!s_active && i2c_req) begin
                s_active = 1'b1; s_cnt = 0; s_idx = int'(cur_idx);
                if (fixed_dly) begin
                    ack_dly = 2; done_dly = 10;
                end else begin
                    ack_dly  = int'($urandom_range(0, 3));
                    done_dly = ack_dly + 1 + int'($urandom_range(0, 8));
                end
                exp_hi = ack_dly + 1;
            end else if (s_active) begin
                s_cnt++;
            end else if (spurious && $urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 1) == 1) i2c_ack = 1'b1;
                else begin i2c_done = 1'b1; i2c_nack = 1'($urandom_range(0, 1)); end
            end
            if (s_active && s_cnt == ack_dly) i2c_ack = 1'b1;
            if (s_active && s_cnt == done_dly) begin
                i2c_done = 1'b1;
                i2c_nack = (s_idx == nack_idx && att[s_idx] < nack_times);
                att[s_idx]++;
                s_active = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            ack1 = 1'b0; done1 = 1'b0; s1_act = 1'b0; prev1 = 1'b0;
        end else begin
            if (req1 && !prev1) n_req1++;
            prev1 = req1;
            ack1 = 1'b0; done1 = 1'b0;
            if (!s1_act && req1) begin
                s1_act = 1'b1; s1_cnt = 0; ack1 = 1'b1;
            end else if (s1_act) begin
                s1_cnt++;
                if (s1_cnt == 3) begin done1 = 1'b1; s1_act = 1'b0; end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic set_policy(input int nidx, input int ntimes);
        nack_idx = nidx; nack_times = ntimes;
        foreach (att[i]) att[i] = 0;
    endtask

    // Optionally fires start pulses mid-pass (entries 1..9 while busy); they must not disturb the stream.
    task automatic wait_end(input bit noise, input string tag);
        int c;
        c = 0;
        while (!((cfg_done || cfg_error) && !busy) && c < 4000) begin
            @(negedge clk);
            c++;
            start = noise && busy && cur_idx >= 4'd1 && cur_idx <= 4'd9 && $urandom_range(0, 3) == 0;
        end
        start = 1'b0;
        check({tag, "_timeout"}, c < 4000, 1);
    endtask

    task automatic end_checks(input string tag, input bit err);
        check({tag, "_cfg_done"}, cfg_done, !err);
        check({tag, "_cfg_error"}, cfg_error, err);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_queue_left"}, sb_q.size(), 0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; start1 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req", i2c_req, 0);
        check("rst_word", i2c_word, 0);
        check("rst_dev", i2c_dev, 7'h1A);
        check("rst_busy", busy, 0);
        check("rst_done", cfg_done, 0);
        check("rst_error", cfg_error, 0);
        check("rst_idx", cur_idx, 0);

        // automatic pass after power-up delay, spec-timed slave
        set_policy(-1, 0);
        void'(model_pass(-1, 0, NREG));
        @(negedge clk); #1 reset_n = 1'b1;
        wait_end(1'b0, "auto");
        end_checks("auto", 1'b0);
        check("auto_last_idx", cur_idx, 10);

        // manual instance: silent until start, then 2-cycle request latency
        check("manual_no_req", n_req1, 0);
        check("manual_no_done", cfg_done1, 0);
        started1 = 1'b1;
        @(negedge clk); start1 = 1'b1; lat = 0;
        do begin @(negedge clk); start1 = 1'b0; lat++; end while (!req1 && lat < 20);
        check("manual_latency", lat, 2);
        check("manual_first_word", word1, 16'h1E00);
        cyc = 0;
        while (!cfg_done1 && cyc < 2000) begin @(negedge clk); cyc++; end
        check("manual_done", cfg_done1, 1);
        check("manual_reqs", n_req1, NREG);
        check("manual_last_word", word1, 16'h1201);

        // entry 3 NACKed twice, random slave timing, stray handshakes and ignored starts
        fixed_dly = 1'b0; spurious = 1'b1;
        set_policy(3, 2);
        exp_err = model_pass(3, 2, NREG);
        pulse_start();
        wait_end(1'b1, "nack3");
        end_checks("nack3", exp_err);

        // entry 5 always NACKed: abort after retries, then silence
        set_policy(5, 255);
        exp_err = model_pass(5, 255, NREG);
        pulse_start();
        wait_end(1'b0, "nack5");
        end_checks("nack5", exp_err);
        nr = n_req;
        repeat (40) @(negedge clk);
        check("no_req_after_error", n_req, nr);

        set_policy(-1, 0);
        void'(model_pass(-1, 0, NREG));
        pulse_start();
        @(negedge clk);
        check("restart_error_cleared", cfg_error, 0);
        check("restart_req_latency", i2c_req, 1);
        check("restart_idx", cur_idx, 0);
        wait_end(1'b1, "restart");
        end_checks("restart", 1'b0);

        for (int k = 0; k < 6; k++) begin
            set_policy(int'($urandom_range(0, 10)), int'($urandom_range(0, 5)));
            exp_err = model_pass(nack_idx, nack_times, NREG);
            pulse_start();
            wait_end(1'b1, "rand");
            end_checks("rand", exp_err);
        end

        // reset during WAIT_DONE of entry 4
        fixed_dly = 1'b1; spurious = 1'b0;
        set_policy(-1, 0);
        void'(model_pass(-1, 0, 5));
        pulse_start();
        cyc = 0;
        while (!(cur_idx == 4'd4 && i2c_req) && cyc < 1000) begin @(negedge clk); cyc++; end
        while (i2c_req && cyc < 1000) begin @(negedge clk); cyc++; end
        check("mid_reset_reach", cyc < 1000, 1);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_req", i2c_req, 0);
        check("mid_rst_word", i2c_word, 0);
        check("mid_rst_dev", i2c_dev, 7'h1A);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", cfg_done, 0);
        check("mid_rst_error", cfg_error, 0);
        check("mid_rst_idx", cur_idx, 0);
        check("mid_rst_queue", sb_q.size(), 0);
        repeat (3) @(negedge clk);
        void'(model_pass(-1, 0, NREG));
        @(negedge clk); #2 reset_n = 1'b1;
        lat = 0;
        while (!i2c_req && lat < 100) begin @(negedge clk); lat++; end
        check("post_rst_latency", lat, STARTUP + 1);
        wait_end(1'b0, "post_rst");
        end_checks("post_rst", 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
